// File: rtl/rgb_gray_stream.sv
// RGB24 -> gray stream stage: 3x64-bit words in (8 pixels), 3 words out with R=G=B=luma.
// Latency: 3rd input accept at edge N -> s2mm_valid from cycle N+2; 7 cycles per group unstalled.
// Backpressure: mm2s_ready only in GATHER; s2mm_valid/data hold until s2mm_ready, stalls are lossless.
module rgb_gray_stream #(
    parameter int WORD_COUNT = 345600,
    parameter int COUNT_W    = 19,
    parameter int R_COEF     = 77,
    parameter int G_COEF     = 150,
    parameter int B_COEF     = 29
) (
    input  logic        m_axi_acp_aclk,
    input  logic        axi_reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [63:0] mm2s_data,
    input  logic        mm2s_valid,
    output logic        mm2s_ready,
    output logic [63:0] s2mm_data,
    output logic        s2mm_valid,
    input  logic        s2mm_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATHER,
        S_COMPUTE,
        S_EMIT,
        S_DONE
    } state_t;

    // Last word index of a frame; the 3rd output handshake of the final group sees this count.
    localparam logic [COUNT_W-1:0] LAST_WORD = COUNT_W'(WORD_COUNT - 1);

    state_t              state;
    logic [1:0]          grp_idx;
    logic [COUNT_W-1:0]  word_cnt;
    logic [2:0][63:0]    grp_buf;
    logic [2:0][63:0]    gray_buf;
    logic [191:0]        grp_flat;
    logic [191:0]        gray_next;
    logic [7:0][15:0]    px_sum;

    assign grp_flat = grp_buf;

    // Weighted luma per pixel, then each of the 24 byte lanes takes its owning pixel's gray.
    always_comb begin
        px_sum    = '0;
        gray_next = '0;
        for (int k = 0; k < 8; k++) begin
            px_sum[k] = 16'(R_COEF) * {8'd0, grp_flat[24*k +: 8]}
                      + 16'(G_COEF) * {8'd0, grp_flat[24*k + 8 +: 8]}
                      + 16'(B_COEF) * {8'd0, grp_flat[24*k + 16 +: 8]};
        end
        for (int b = 0; b < 24; b++) begin
            gray_next[8*b +: 8] = px_sum[b/3][15:8];
        end
    end

    // Frame control FSM with all handshake and status outputs registered.
    always_ff @(posedge m_axi_acp_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mm2s_ready <= 1'b0;
            s2mm_valid <= 1'b0;
            s2mm_data  <= '0;
            grp_idx    <= '0;
            word_cnt   <= '0;
            grp_buf    <= '0;
            gray_buf   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_GATHER;
                        busy       <= 1'b1;
                        mm2s_ready <= 1'b1;
                        word_cnt   <= '0;
                        grp_idx    <= '0;
                    end
                end
                S_GATHER: begin
                    if (mm2s_valid && mm2s_ready) begin
                        grp_buf[grp_idx] <= mm2s_data;
                        grp_idx          <= grp_idx + 2'd1;
                        if (grp_idx == 2'd2) begin
                            mm2s_ready <= 1'b0;
                            state      <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    // Word 0 is presented straight from the adder tree so EMIT starts valid.
                    gray_buf   <= gray_next;
                    s2mm_data  <= gray_next[63:0];
                    s2mm_valid <= 1'b1;
                    grp_idx    <= '0;
                    state      <= S_EMIT;
                end
                S_EMIT: begin
                    if (s2mm_valid && s2mm_ready) begin
                        word_cnt <= word_cnt + COUNT_W'(1);
                        if (grp_idx == 2'd2) begin
                            grp_idx    <= '0;
                            s2mm_valid <= 1'b0;
                            if (word_cnt == LAST_WORD) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state      <= S_GATHER;
                                mm2s_ready <= 1'b1;
                            end
                        end else begin
                            grp_idx   <= grp_idx + 2'd1;
                            s2mm_data <= gray_buf[grp_idx + 2'd1];
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_gray_stream.sv
// Bench for rgb_gray_stream: two instances (3-word and 6-word frames) behind a select mux.
// A queue model turns every accepted 3-word group into the expected gray words.
// Directed frames add literal expectations, stalls, start pulses and a mid-frame reset.
`timescale 1ns/1ps
module tb_rgb_gray_stream;

    logic        clk;
    logic        axi_reset;
    logic        start;
    logic        sel;
    logic [63:0] mm2s_data;
    logic        mm2s_valid;
    logic        s2mm_ready;

    logic        busy_a, done_a, mm2s_ready_a, s2mm_valid_a;
    logic [63:0] s2mm_data_a;
    logic        busy_b, done_b, mm2s_ready_b, s2mm_valid_b;
    logic [63:0] s2mm_data_b;
    logic        start_a, start_b;

    logic        busy, done, mm2s_ready, s2mm_valid;
    logic [63:0] s2mm_data;

    assign start_a    = start & ~sel;
    assign start_b    = start & sel;
    assign busy       = sel ? busy_b       : busy_a;
    assign done       = sel ? done_b       : done_a;
    assign mm2s_ready = sel ? mm2s_ready_b : mm2s_ready_a;
    assign s2mm_valid = sel ? s2mm_valid_b : s2mm_valid_a;
    assign s2mm_data  = sel ? s2mm_data_b  : s2mm_data_a;

    rgb_gray_stream #(.WORD_COUNT(3), .COUNT_W(2)) u3 (
        .m_axi_acp_aclk(clk), .axi_reset(axi_reset), .start(start_a),
        .busy(busy_a), .done(done_a),
        .mm2s_data(mm2s_data), .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready_a),
        .s2mm_data(s2mm_data_a), .s2mm_valid(s2mm_valid_a), .s2mm_ready(s2mm_ready)
    );

    rgb_gray_stream #(.WORD_COUNT(6), .COUNT_W(4)) u6 (
        .m_axi_acp_aclk(clk), .axi_reset(axi_reset), .start(start_b),
        .busy(busy_b), .done(done_b),
        .mm2s_data(mm2s_data), .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready_b),
        .s2mm_data(s2mm_data_b), .s2mm_valid(s2mm_valid_b), .s2mm_ready(s2mm_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [63:0] in_buf[$];
    logic [63:0] exp_q[$];
    logic [63:0] out_log[$];

    logic        prev_stall, prev_done, prev_hs;
    logic [63:0] prev_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within budget", nm);
    endtask

    function automatic int gray_of(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    // Expected output: byte b of the group carries the gray of pixel b/3.
    task automatic model_group();
        logic [191:0] grp;
        logic [63:0]  ow;
        int px;
        int gv;
        grp = {in_buf[2], in_buf[1], in_buf[0]};
        for (int j = 0; j < 3; j++) begin
            ow = '0;
            for (int bb = 0; bb < 8; bb++) begin
                px = (8 * j + bb) / 3;
                gv = gray_of(int'(grp[24*px +: 8]), int'(grp[24*px + 8 +: 8]), int'(grp[24*px + 16 +: 8]));
                ow[8*bb +: 8] = gv[7:0];
            end
            exp_q.push_back(ow);
        end
        in_buf.delete();
    endtask

    // Per-cycle monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (axi_reset) begin
            in_buf.delete();
            exp_q.delete();
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (mm2s_valid && mm2s_ready) begin
                in_buf.push_back(mm2s_data);
                if (in_buf.size() == 3) model_group();
            end
            if (prev_stall) begin
                chk("hold_valid", s2mm_valid, 1'b1);
                chk("hold_data", s2mm_data, prev_data);
            end
            if (s2mm_valid && s2mm_ready) begin
                if (exp_q.size() == 0) fail("unexpected_output");
                else chk("out_word", s2mm_data, exp_q.pop_front());
                out_log.push_back(s2mm_data);
            end
            if (s2mm_valid) chk("no_input_while_emit", mm2s_ready, 1'b0);
            if (done) begin
                done_cnt++;
                chk("done_after_last_hs", prev_hs, 1'b1);
                chk("busy_during_done", busy, 1'b1);
            end
            if (prev_done) chk("busy_after_done", busy, 1'b0);
            prev_stall = s2mm_valid && !s2mm_ready;
            prev_data  = s2mm_data;
            prev_done  = done;
            prev_hs    = s2mm_valid && s2mm_ready;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] w, input int gaps);
        bit ok;
        for (int g = 0; g < gaps; g++) begin
            mm2s_valid = 1'b0;
            mm2s_data  = 64'($urandom);
            @(posedge clk); #1;
        end
        mm2s_data  = w;
        mm2s_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mm2s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("input_accept_timeout");
        @(posedge clk); #1;
        mm2s_valid = 1'b0;
    endtask

    task automatic push_group(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2, input int max_gap);
        push_word(w0, $urandom_range(0, max_gap));
        push_word(w1, $urandom_range(0, max_gap));
        push_word(w2, $urandom_range(0, max_gap));
    endtask

    task automatic wait_done(input string nm);
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) break;
        end
        if (done_cnt < target) fail(nm);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s2mm_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail(nm);
    endtask

    task automatic chk_log(input string nm, input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
        chk({nm, "_count"}, 64'(out_log.size()), 64'd3);
        if (out_log.size() >= 3) begin
            chk({nm, "_w0"}, out_log[0], e0);
            chk({nm, "_w1"}, out_log[1], e1);
            chk({nm, "_w2"}, out_log[2], e2);
        end
    endtask

    // Hard stop in case a phase wedges outside the bounded loops.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d0;
        int          dc;

        axi_reset  = 1'b1;
        start      = 1'b0;
        sel        = 1'b0;
        mm2s_valid = 1'b0;
        mm2s_data  = '0;
        s2mm_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {busy_a, busy_b}, 2'b00);
        chk("rst_done", {done_a, done_b}, 2'b00);
        chk("rst_mm2s_ready", {mm2s_ready_a, mm2s_ready_b}, 2'b00);
        chk("rst_s2mm_valid", {s2mm_valid_a, s2mm_valid_b}, 2'b00);
        chk("rst_s2mm_data_a", s2mm_data_a, 64'd0);
        chk("rst_s2mm_data_b", s2mm_data_b, 64'd0);
        axi_reset = 1'b0;

        chk("model_red", 64'(gray_of(255, 0, 0)), 64'd76);
        chk("model_green", 64'(gray_of(0, 255, 0)), 64'd149);
        chk("model_blue", 64'(gray_of(0, 0, 255)), 64'd28);
        chk("model_white", 64'(gray_of(255, 255, 255)), 64'd255);

        // Pure red, single group frame.
        out_log.delete();
        pulse_start();
        chk("busy_after_start", busy, 1'b1);
        chk("ready_after_start", mm2s_ready, 1'b1);
        push_group(64'h00FF0000FF0000FF, 64'hFF0000FF0000FF00, 64'h0000FF0000FF0000, 0);
        wait_done("red_done");
        chk_log("red", {8{8'h4C}}, {8{8'h4C}}, {8{8'h4C}});

        // Single-channel pixel 0 and uniform extremes.
        out_log.delete();
        pulse_start();
        push_group(64'h0000_0000_0000_FF00, 64'd0, 64'd0, 1);
        wait_done("g0_done");
        chk_log("g0", 64'h0000_0000_0095_9595, 64'd0, 64'd0);

        out_log.delete();
        pulse_start();
        push_group(64'h0000_0000_00FF_0000, 64'd0, 64'd0, 1);
        wait_done("b0_done");
        chk_log("b0", 64'h0000_0000_001C_1C1C, 64'd0, 64'd0);

        out_log.delete();
        pulse_start();
        push_group({64{1'b1}}, {64{1'b1}}, {64{1'b1}}, 0);
        wait_done("white_done");
        chk_log("white", {64{1'b1}}, {64{1'b1}}, {64{1'b1}});

        out_log.delete();
        pulse_start();
        push_group(64'd0, 64'd0, 64'd0, 0);
        wait_done("black_done");
        chk_log("black", 64'd0, 64'd0, 64'd0);

        // Output backpressure for 5 cycles during EMIT.
        out_log.delete();
        s2mm_ready = 1'b0;
        pulse_start();
        push_group(64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'h1716151413121110, 0);
        wait_out_valid("bp_valid");
        d0 = s2mm_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", s2mm_valid, 1'b1);
            chk("bp_data_held", s2mm_data, d0);
            chk("bp_no_input", mm2s_ready, 1'b0);
        end
        @(posedge clk); #1 s2mm_ready = 1'b1;
        wait_done("bp_done");
        chk("bp_count", 64'(out_log.size()), 64'd3);

        // Six-word frame with random input gaps.
        sel = 1'b1;
        dc  = done_cnt;
        pulse_start();
        push_group(64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'h1716151413121110, 3);
        push_group(64'h123456789ABCDEF0, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 3);
        wait_done("gap_done");
        repeat (5) @(posedge clk);
        #1;
        chk("gap_word_cnt", 64'(u6.word_cnt), 64'd6);
        chk("gap_done_pulses", 64'(done_cnt - dc), 64'd1);
        chk("gap_busy_idle", busy, 1'b0);
        sel = 1'b0;
        @(posedge clk); #1;

        // Extra start pulses in GATHER and EMIT are ignored.
        out_log.delete();
        dc = done_cnt;
        s2mm_ready = 1'b0;
        pulse_start();
        push_word(64'hFF0000FF0000FF00, 0);
        pulse_start();
        push_word(64'h0000FF0000FF0000, 0);
        push_word(64'h00FF0000FF0000FF, 0);
        wait_out_valid("start_ign_valid");
        pulse_start();
        @(posedge clk); #1 s2mm_ready = 1'b1;
        wait_done("start_ign_done");
        repeat (3) @(posedge clk);
        #1;
        chk_log("green", {8{8'h95}}, {8{8'h95}}, {8{8'h95}});
        chk("start_ign_done_pulses", 64'(done_cnt - dc), 64'd1);
        chk("start_ign_idle", busy, 1'b0);

        // Asynchronous reset in the middle of EMIT.
        dc = done_cnt;
        s2mm_ready = 1'b0;
        pulse_start();
        push_group(64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 0);
        wait_out_valid("rst_emit_valid");
        @(posedge clk); #3 axi_reset = 1'b1;
        #1;
        chk("arst_s2mm_valid", s2mm_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_mm2s_ready", mm2s_ready, 1'b0);
        @(posedge clk); #1 axi_reset = 1'b0;
        s2mm_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_no_done", 64'(done_cnt - dc), 64'd0);
        out_log.delete();
        pulse_start();
        push_group(64'h0000FF0000FF0000, 64'h00FF0000FF0000FF, 64'hFF0000FF0000FF00, 1);
        wait_done("post_rst_done");
        chk_log("blue", {8{8'h1C}}, {8{8'h1C}}, {8{8'h1C}});

        chk("model_drained", 64'(exp_q.size()), 64'd0);
        chk("input_drained", 64'(in_buf.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
